// File: rtl/pad_ctrl_pkg.sv
// Shared types and defaults for the pad output-enable sequencer.
// Holds the FSM state encoding and the default group/gap sizing.
package pad_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam int DEF_NPADS      = 16;
  localparam int DEF_GROUP_SIZE = 4;
  localparam int DEF_GAPW       = 8;

endpackage

// File: rtl/pad_gap_counter.sv
// Loadable down-counter with zero flag, used to space group updates.
// Saturates at zero so a stray decrement can never wrap.
module pad_gap_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pad_oe_sequencer.sv
// Applies a new pad output-enable pattern one group at a time,
// with a programmable idle gap between groups to limit SSN.
module pad_oe_sequencer
  import pad_ctrl_pkg::*;
#(
  parameter int NPADS      = DEF_NPADS,
  parameter int GROUP_SIZE = DEF_GROUP_SIZE,
  parameter int GAPW       = DEF_GAPW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [NPADS-1:0] target_oe_i,
  input  logic [GAPW-1:0]  gap_cycles_i,
  input  logic             force_off_i,
  output logic [NPADS-1:0] pad_oe_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int NGROUPS = NPADS / GROUP_SIZE;
  localparam int GIW = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  state_e           state_q, state_d;
  logic [GIW-1:0]   grp_q, grp_d;
  logic [NPADS-1:0] tgt_q, tgt_d;
  logic [GAPW-1:0]  gap_q, gap_d;
  logic [NPADS-1:0] pad_q, pad_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic last_grp;
  logic accept;

  assign last_grp = (grp_q == GIW'(NGROUPS - 1));
  assign accept   = req_valid_i && req_ready_o;

  // Counter holds gap-1 so WAIT exits on the zero flag after gap cycles.
  pad_gap_counter #(
    .W (GAPW)
  ) u_gap_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (force_off_i),
    .load_i (cnt_load),
    .val_i  (gap_q - GAPW'(1)),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    tgt_d    = tgt_q;
    gap_d    = gap_q;
    pad_d    = pad_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tgt_d   = target_oe_i;
          gap_d   = gap_cycles_i;
          grp_d   = '0;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        for (int k = 0; k < NGROUPS; k++) begin
          if (grp_q == GIW'(k)) begin
            pad_d[k*GROUP_SIZE +: GROUP_SIZE] =
              tgt_q[k*GROUP_SIZE +: GROUP_SIZE];
          end
        end
        if (last_grp) begin
          state_d = ST_DONE;
        end else if (gap_q == '0) begin
          grp_d = grp_q + GIW'(1);
        end else begin
          cnt_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          grp_d   = grp_q + GIW'(1);
          state_d = ST_APPLY;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase

    if (force_off_i) begin
      state_d  = ST_IDLE;
      pad_d    = '0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grp_q   <= '0;
      tgt_q   <= '0;
      gap_q   <= '0;
      pad_q   <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      tgt_q   <= tgt_d;
      gap_q   <= gap_d;
      pad_q   <= pad_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE) && !force_off_i;
  assign pad_oe_o    = pad_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: doc/pad_oe_sequencer.md
PAD_OE_SEQUENCER -- requirements
Module: pad_oe_sequencer

Interface
REQ-001 Parameter NPADS, default 16, number of controlled output pads; SHALL be a multiple of GROUP_SIZE.
REQ-002 Parameter GROUP_SIZE, default 4, pads switched together per step; NGROUPS = NPADS/GROUP_SIZE.
REQ-003 Parameter GAPW, default 8, width of the inter-group gap counter.
REQ-004 clk_i  input  1  single block clock; all state on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 req_valid_i  input  1  new target OE pattern offered.
REQ-007 req_ready_o  output  1  sequencer can accept a request.
REQ-008 target_oe_i  input  NPADS  desired final output-enable per pad; bit i drives pad i.
REQ-009 gap_cycles_i  input  GAPW  idle cycles inserted between consecutive group updates.
REQ-010 force_off_i  input  1  emergency disable of all pads.
REQ-011 pad_oe_o  output  NPADS  registered output enables, one per pad cell pad_oe_i.
REQ-012 busy_o  output  1  high in any state other than IDLE.
REQ-013 done_o  output  1  one-cycle pulse when a sequence completes normally.

Function
REQ-014 Purpose: limit simultaneous switching noise by applying OE changes group by group, never all pads on one edge.
REQ-015 FSM states SHALL be IDLE, APPLY, WAIT, DONE.
REQ-016 req_ready_o = (state==IDLE) and not force_off_i; handshake occurs on an edge where req_valid_i and req_ready_o are both high.
REQ-017 On the handshake edge T: target_oe_i and gap_cycles_i are latched, group index := 0, state := APPLY; pad_oe_o unchanged.
REQ-018 APPLY: next edge writes pad_oe_o[g*GROUP_SIZE +: GROUP_SIZE] from the latched target; other bits hold.
REQ-019 From APPLY: if g==NGROUPS-1 -> DONE; else if gap==0 -> APPLY with g+1; else -> WAIT with counter := gap.
REQ-020 WAIT: counter decrements each edge; on the edge where it reaches 1 -> APPLY with g+1.
REQ-021 Group k SHALL be written on edge T+1+k*(gap+1); a group is written even if its bits are unchanged (deterministic timing).
REQ-022 DONE: done_o high exactly one cycle, then -> IDLE; done_o never asserted outside DONE.
REQ-023 force_off_i high at any edge: pad_oe_o := 0, state := IDLE, no done_o pulse, any in-flight sequence discarded.
REQ-024 force_off_i and req_valid_i high together: force wins, request not accepted.
REQ-025 Input changes on target_oe_i/gap_cycles_i after the handshake SHALL have no effect on the running sequence.
REQ-026 gap_cycles_i at maximum (2^GAPW-1) SHALL sequence correctly without counter wrap.

Reset
REQ-027 Asserting rst_i SHALL immediately (asynchronously) force state IDLE, pad_oe_o=0, done_o=0, busy_o=0, counters and latched target to 0.
REQ-028 req_ready_o SHALL be 1 in the first cycle after rst_i deasserts if force_off_i is low.
REQ-029 Reset mid-sequence SHALL leave all pads disabled; no partial group persists.

Structure
REQ-030 Shared package pad_ctrl_pkg SHALL hold the FSM state enum and default GROUP_SIZE/GAPW constants.
REQ-031 One sub-module, pad_gap_counter (loadable down-counter with zero flag), is natural; everything else in one module.
REQ-032 pad_oe_o SHALL be driven directly from flops, no combinational path from any input.

Verification
REQ-033 NPADS=16, GROUP_SIZE=4, gap=2, target=0xFFFF, handshake at edge T -> pad_oe_o = 0x000F @T+1, 0x00FF @T+4, 0x0FFF @T+7, 0xFFFF @T+10, done_o high cycle after T+10, req_ready_o high one cycle later.
REQ-034 gap=0, target=0xA5A5 from 0 -> one nibble per edge T+1..T+4, final 0xA5A5, done_o once.
REQ-035 force_off_i pulsed at T+5 of REQ-033 run -> pad_oe_o=0 next edge, state IDLE, no done_o pulse.
REQ-036 req_valid_i held high while busy -> no second acceptance until after DONE; target_oe_i changed mid-run ignored.
REQ-037 rst_i asserted asynchronously mid-WAIT -> pad_oe_o=0 and busy_o=0 without a clock edge.
REQ-038 gap=255 -> group spacing exactly 256 cycles, total sequence completes with done_o at T+1+3*256+1.
